gpr_file: RTL and testbench

// - 32 x 64-bit general-purpose register file for the dual-issue PowerPC pipeline core.
// - Two read ports are driven by the decode stage; two write ports are driven by the WB0/WB1 write-back slots.
// - Port 1 carries the younger instruction of an issue pair.

---
 rtl/ppc_pkg.sv | 12 +
 rtl/gpr_read_port.sv | 43 ++++
 rtl/gpr_file.sv | 70 +++++++
 tb/tb_gpr_file.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ppc_pkg.sv
// Shared core-wide constants and types for the PowerPC pipeline.
// Buses are big-endian numbered: bit 0 is the MSB.
package ppc_pkg;

  localparam int GPR_COUNT = 32;
  localparam int GPR_AW    = 5;
  localparam int XLEN      = 64;

  typedef logic [0:GPR_AW-1] gpr_addr_t;
  typedef logic [0:XLEN-1]   xlen_t;

endpackage

// File: rtl/gpr_read_port.sv
// GPR read port: write-first bypass mux and output register; latency 1.
// No backpressure: readEn=0 holds readData, a write bypass always takes effect on the same edge.
module gpr_read_port
  import ppc_pkg::*;
#(
  parameter int AW = GPR_AW,
  parameter int DW = XLEN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          readEn,
  input  logic [0:AW-1] readAddr,
  input  logic [0:DW-1] storedData,
  input  logic          writeEn0,
  input  logic [0:AW-1] writeAddr0,
  input  logic [0:DW-1] writeData0,
  input  logic          writeEn1,
  input  logic [0:AW-1] writeAddr1,
  input  logic [0:DW-1] writeData1,
  output logic [0:DW-1] readData
);

  logic [0:DW-1] bypassData;

  // Port 1 is the younger instruction, so its write shadows port 0's.
  always_comb begin
    bypassData = storedData;
    if (writeEn1 && (writeAddr1 == readAddr)) begin
      bypassData = writeData1;
    end else if (writeEn0 && (writeAddr0 == readAddr)) begin
      bypassData = writeData0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readData <= '0;
    end else if (readEn) begin
      readData <= bypassData;
    end
  end

endmodule

// File: rtl/gpr_file.sv
// 32x64 GPR file, two registered read ports (latency 1, write-first) and two write ports.
// No backpressure: every enabled access completes on the edge it is presented.
module gpr_file
  import ppc_pkg::*;
#(
  parameter int NREGS = GPR_COUNT,
  parameter int AW    = GPR_AW,
  parameter int DW    = XLEN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          readEn0,
  input  logic [0:AW-1] readAddr0,
  output logic [0:DW-1] readData0,
  input  logic          readEn1,
  input  logic [0:AW-1] readAddr1,
  output logic [0:DW-1] readData1,
  input  logic          writeEn0,
  input  logic [0:AW-1] writeAddr0,
  input  logic [0:DW-1] writeData0,
  input  logic          writeEn1,
  input  logic [0:AW-1] writeAddr1,
  input  logic [0:DW-1] writeData1
);

  xlen_t regs [0:NREGS-1];

  // Port 1 assigned last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (writeEn0) regs[writeAddr0] <= writeData0;
      if (writeEn1) regs[writeAddr1] <= writeData1;
    end
  end

  gpr_read_port #(.AW(AW), .DW(DW)) uRead0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .readEn     (readEn0),
    .readAddr   (readAddr0),
    .storedData (regs[readAddr0]),
    .writeEn0   (writeEn0),
    .writeAddr0 (writeAddr0),
    .writeData0 (writeData0),
    .writeEn1   (writeEn1),
    .writeAddr1 (writeAddr1),
    .writeData1 (writeData1),
    .readData   (readData0)
  );

  gpr_read_port #(.AW(AW), .DW(DW)) uRead1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .readEn     (readEn1),
    .readAddr   (readAddr1),
    .storedData (regs[readAddr1]),
    .writeEn0   (writeEn0),
    .writeAddr0 (writeAddr0),
    .writeData0 (writeData0),
    .writeEn1   (writeEn1),
    .writeAddr1 (writeAddr1),
    .writeData1 (writeData1),
    .readData   (readData1)
  );

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: directed vector table, sweep and async reset sequence.
module tb_gpr_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        readEn0 = 1'b0, readEn1 = 1'b0;
  logic [0:4]  readAddr0 = '0, readAddr1 = '0;
  logic [0:63] readData0, readData1;
  logic        writeEn0 = 1'b0, writeEn1 = 1'b0;
  logic [0:4]  writeAddr0 = '0, writeAddr1 = '0;
  logic [0:63] writeData0 = '0, writeData1 = '0;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  gpr_file dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .readEn0    (readEn0),
    .readAddr0  (readAddr0),
    .readData0  (readData0),
    .readEn1    (readEn1),
    .readAddr1  (readAddr1),
    .readData1  (readData1),
    .writeEn0   (writeEn0),
    .writeAddr0 (writeAddr0),
    .writeData0 (writeData0),
    .writeEn1   (writeEn1),
    .writeAddr1 (writeAddr1),
    .writeData1 (writeData1)
  );

  typedef struct {
    logic        we0; logic [4:0] wa0; logic [63:0] wd0;
    logic        we1; logic [4:0] wa1; logic [63:0] wd1;
    logic        re0; logic [4:0] ra0;
    logic        re1; logic [4:0] ra1;
    logic        chk0; logic [63:0] exp0;
    logic        chk1; logic [63:0] exp1;
  } vec_t;

  typedef struct {
    int          port;
    logic [63:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one cycle at negedge, queue expectations, compare 1ns after the posedge.
  task automatic applyVec(input vec_t v, input string tag);
    exp_t e;
    logic [63:0] act;
    @(negedge clk);
    writeEn0 = v.we0; writeAddr0 = v.wa0; writeData0 = v.wd0;
    writeEn1 = v.we1; writeAddr1 = v.wa1; writeData1 = v.wd1;
    readEn0 = v.re0; readAddr0 = v.ra0;
    readEn1 = v.re1; readAddr1 = v.ra1;
    if (v.chk0) sb.push_back('{0, v.exp0, tag});
    if (v.chk1) sb.push_back('{1, v.exp1, tag});
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = (e.port == 0) ? readData0 : readData1;
      check($sformatf("%s port%0d", e.tag, e.port), act, e.val);
    end
  endtask

  task automatic idle();
    vec_t v;
    v = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 64'd0};
    applyVec(v, "idle");
  endtask

  initial begin
    vec_t v;
    // we0 wa0 wd0 | we1 wa1 wd1 | re0 ra0 | re1 ra1 | chk0 exp0 | chk1 exp1
    tbl[0] = '{1, 3,  64'h0123456789ABCDEF, 0, 0,  64'h0,  0, 0,  0, 0,  1, 64'h0,  1, 64'h0};
    tbl[1] = '{0, 0,  64'h0,  0, 0,  64'h0,  0, 0,  1, 3,  1, 64'h0,  1, 64'h0123456789ABCDEF};
    tbl[2] = '{1, 7,  64'h11, 1, 7,  64'h22, 0, 0,  0, 0,  0, 64'h0,  1, 64'h0123456789ABCDEF};
    tbl[3] = '{0, 0,  64'h0,  0, 0,  64'h0,  1, 7,  1, 7,  1, 64'h22, 1, 64'h22};
    tbl[4] = '{1, 9,  64'hAA, 1, 10, 64'hBB, 1, 9,  1, 10, 1, 64'hAA, 1, 64'hBB};
    tbl[5] = '{1, 12, 64'h1,  1, 12, 64'h2,  1, 12, 1, 9,  1, 64'h2,  1, 64'hAA};
    tbl[6] = '{1, 3,  64'h55, 0, 0,  64'h0,  1, 3,  0, 0,  1, 64'h55, 1, 64'hAA};
    tbl[7] = '{1, 3,  64'h66, 0, 0,  64'h0,  0, 3,  1, 3,  1, 64'h55, 1, 64'h66};
    tbl[8] = '{0, 0,  64'h0,  0, 0,  64'h0,  1, 3,  1, 12, 1, 64'h66, 1, 64'h2};
    tbl[9] = '{0, 0,  64'h0,  1, 0,  64'hDEAD, 1, 0, 0, 0, 1, 64'hDEAD, 1, 64'h2};

    // Reset state while held low.
    #12;
    check("reset readData0", readData0, 64'h0);
    check("reset readData1", readData1, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyVec(tbl[i], $sformatf("vec%0d", i));
    end

    // Sweep: fill all registers two per cycle, then read back on both ports.
    for (int i = 0; i < 32; i += 2) begin
      v = '{1, 5'(i), 64'(i) * 64'h0101010101010101,
            1, 5'(i + 1), 64'(i + 1) * 64'h0101010101010101,
            0, 0, 0, 0, 0, 64'h0, 0, 64'h0};
      applyVec(v, "sweepWr");
    end
    for (int i = 0; i < 32; i++) begin
      v = '{0, 0, 64'h0, 0, 0, 64'h0,
            1, 5'(i), 1, 5'((i + 5) % 32),
            1, 64'(i) * 64'h0101010101010101,
            1, 64'((i + 5) % 32) * 64'h0101010101010101};
      applyVec(v, $sformatf("sweepRd%0d", i));
    end

    // Asynchronous reset mid-cycle must clear outputs immediately.
    @(negedge clk);
    readEn0 = 1'b0; readEn1 = 1'b0;
    #2;
    check("preReset readData0", readData0, 64'h1F1F1F1F1F1F1F1F);
    check("preReset readData1", readData1, 64'h0404040404040404);
    rst_n = 1'b0;
    #1;
    check("asyncReset readData0", readData0, 64'h0);
    check("asyncReset readData1", readData1, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("heldReset readData0", readData0, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    v = '{0, 0, 64'h0, 0, 0, 64'h0, 1, 5, 1, 3, 1, 64'h0, 1, 64'h0};
    applyVec(v, "postReset r5/r3");
    v = '{0, 0, 64'h0, 0, 0, 64'h0, 1, 31, 1, 0, 1, 64'h0, 1, 64'h0};
    applyVec(v, "postReset r31/r0");
    idle();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
